if_pc_ctrl: RTL and testbench
=============================

// Module: if_pc_ctrl
// PURPOSE
//  Owns the fetch PC register and the IF/ID pipeline register in the pipe core.
//  Drives IF_pc into the fetch unit and takes back the predicted next PC, instr, prdt_taken and fetch excp flags.
//  Sequences the fetch unit: resolves trap redirects, EX mispredict redirects and ID back-pressure.
//  Parks fetch after a faulting fetch until the trap is taken.
// PARAMETERS
//  RESET_PC   64'h8000_0000   PC loaded on reset; first fetch address.
// PORTS
//  clk              in   1             core clock
//  rst              in   1             asynchronous, active-high reset
//  IF_pc_o          out  `PC_WIDTH     current fetch PC to fetch unit
//  ifu_pc_next_i    in   `PC_WIDTH     predicted next PC from fetch unit
//  ifu_instr_i      in   `INSTR_WIDTH  fetched instr
//  ifu_prdt_taken_i in   1             static prediction taken
//  ifu_pc_misalign_i in  1             fetch addr misaligned
//  ifu_bus_err_i    in   1             fetch bus error
//  ex_redir_i       in   1             EX mispredict/jalr correction
//  ex_redir_pc_i    in   `PC_WIDTH     corrected PC
//  trap_redir_i     in   1             trap entry/mret redirect
//  trap_redir_pc_i  in   `PC_WIDTH     trap target PC
//  id_ready_i       in   1             ID accepts IF/ID content this cycle
//  ID_valid_o       out  1             IF/ID holds a valid instr
//  ID_pc_o          out  `PC_WIDTH     PC of IF/ID instr
//  ID_instr_o       out  `INSTR_WIDTH  IF/ID instr
//  ID_prdt_taken_o  out  1             IF/ID prediction bit
//  ID_pc_misalign_o out  1             IF/ID excp flag
//  ID_bus_err_o     out  1             IF/ID excp flag
// BEHAVIOUR
//  Reset: IF_pc_o=RESET_PC, ID_valid_o=0, all other ID_* outputs=0, state=RUN. Reset is honoured mid-operation, any state.
//  FSM: RUN (fetching), WAIT_TRAP (fetch parked after fault).
//  accept = ~ID_valid_o | id_ready_i (IF/ID slot free or draining).
//  Per-cycle priority, highest first:
//   1 trap_redir_i: pc<=trap_redir_pc_i; ID_valid<=0; state<=RUN. Overrides stall and ex_redir.
//   2 ex_redir_i: pc<=ex_redir_pc_i; ID_valid<=0; state<=RUN. This also exits WAIT_TRAP, because the fault was on the wrong path.
//   3 RUN & accept: pc<=ifu_pc_next_i; IF/ID<=(1,IF_pc_o,instr,prdt,misalign,bus_err).
//     If misalign|bus_err, state<=WAIT_TRAP.
//   4 RUN & ~accept: pc and IF/ID hold (stall).
//   5 WAIT_TRAP: pc holds; if id_ready_i then ID_valid<=0. No new fetch is captured.
//  Latency: the instr at pc is visible on ID_* one cycle after fetch. A redirect's target is on IF_pc_o the next cycle and in ID the cycle after.
//  Redirect targets are not checked; the fetch unit flags misalignment.
//  ID_* payload holds while ID_valid_o=0 (no-care). Pipe verification checks only qualified values.
//  PC arithmetic is `PC_WIDTH bits, wrap-around, no overflow detect.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs perf_fetch_cnt_o, perf_redir_cnt_o and perf_stall_cnt_o (64b each), reset 0, wrapping.
//   perf_fetch_cnt_o counts case-3 cycles.
//   perf_redir_cnt_o counts cycles with trap_redir_i|ex_redir_i.
//   perf_stall_cnt_o counts RUN & ~accept & no-redirect cycles.
//  IFU_PERF_CNT_EN undefined: no counters, no ports; behaviour otherwise identical.
// STRUCTURE
//  defines.v supplies `PC_WIDTH, `INSTR_WIDTH and `RESET_PC_DEFAULT, plus state encodings IFC_ST_RUN=1'b0 and IFC_ST_WAIT_TRAP=1'b1.
//  One sub-module, ifid_reg: IF/ID payload register with load/clear/hold controls.
//  PC register, FSM and counters stay in if_pc_ctrl.
// TESTING
//  Reset release, id_ready=1, ifu_pc_next=pc+4 -> IF_pc 0x8000_0000, 0x8000_0004, ...; ID_valid rises 1 cycle after reset.
//  id_ready=0 for 3 cycles with ID_valid=1 -> IF_pc and ID_* frozen; on id_ready=1 the next instr loads.
//  ex_redir_i=1 with pc 0x8000_0100 during stall -> next IF_pc=0x8000_0100, ID_valid=0, then valid with pc 0x8000_0100.
//  Same cycle: trap_redir (0x8000_0200) and ex_redir (0x8000_0100) -> IF_pc=0x8000_0200.
//  ifu_bus_err_i=1 at pc 0x8000_0010 -> ID_bus_err=1, fetch parked; trap_redir to mtvec resumes at mtvec.
//  rst asserted while in WAIT_TRAP -> immediate IF_pc=RESET_PC, ID_valid=0, state RUN. With IFU_PERF_CNT_EN, counters also clear to 0.

Source files
------------

// File: rtl/if_pc_ctrl_pkg.sv
// Shared widths, reset PC, FSM encodings and the IF/ID payload type for the fetch PC controller.
// Optional feature macro used by if_pc_ctrl: IFU_PERF_CNT_EN.
package if_pc_ctrl_pkg;

    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    localparam logic [0:0] IFC_ST_RUN       = 1'b0;
    localparam logic [0:0] IFC_ST_WAIT_TRAP = 1'b1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   prdt_taken;
        logic                   pc_misalign;
        logic                   bus_err;
    } ifid_payload_t;

    function automatic logic fetch_fault(input logic pc_misalign, input logic bus_err);
        return pc_misalign | bus_err;
    endfunction

endpackage

// File: rtl/if_pc_ctrl_ifid.sv
// IF/ID pipeline register: load captures a new fetch, clear drops valid while the payload holds.
module ifid_reg
    import if_pc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  ifid_payload_t d,
    output logic          valid,
    output ifid_payload_t q
);

    // Load wins over clear; the payload is left untouched when the slot is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= q;
        end else begin
            valid <= valid;
            q     <= q;
        end
    end

endmodule

// File: rtl/if_pc_ctrl.sv
// Fetch PC register, RUN/WAIT_TRAP sequencing and IF/ID register for the pipe core.
// Defining IFU_PERF_CNT_EN adds fetch/redirect/stall performance counters.
module if_pc_ctrl
    import if_pc_ctrl_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    IF_pc_o,
    input  logic [PC_WIDTH-1:0]    ifu_pc_next_i,
    input  logic [INSTR_WIDTH-1:0] ifu_instr_i,
    input  logic                   ifu_prdt_taken_i,
    input  logic                   ifu_pc_misalign_i,
    input  logic                   ifu_bus_err_i,
    input  logic                   ex_redir_i,
    input  logic [PC_WIDTH-1:0]    ex_redir_pc_i,
    input  logic                   trap_redir_i,
    input  logic [PC_WIDTH-1:0]    trap_redir_pc_i,
    input  logic                   id_ready_i,
    output logic                   ID_valid_o,
    output logic [PC_WIDTH-1:0]    ID_pc_o,
    output logic [INSTR_WIDTH-1:0] ID_instr_o,
    output logic                   ID_prdt_taken_o,
    output logic                   ID_pc_misalign_o,
    output logic                   ID_bus_err_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]            perf_fetch_cnt_o,
    output logic [63:0]            perf_redir_cnt_o,
    output logic [63:0]            perf_stall_cnt_o
`endif
);

    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_nxt_s;
    logic [0:0]          state_r;
    logic [0:0]          state_nxt_s;
    logic                accept_s;
    logic                load_s;
    logic                clear_s;
    logic                stall_s;
    ifid_payload_t       fetch_s;
    ifid_payload_t       ifid_q_s;

    assign accept_s = ~ID_valid_o | id_ready_i;

    assign fetch_s.pc          = pc_r;
    assign fetch_s.instr       = ifu_instr_i;
    assign fetch_s.prdt_taken  = ifu_prdt_taken_i;
    assign fetch_s.pc_misalign = ifu_pc_misalign_i;
    assign fetch_s.bus_err     = ifu_bus_err_i;

    // Redirect priority (trap over EX), then fetch/stall in RUN, drain-only in WAIT_TRAP.
    always_comb begin
        pc_nxt_s    = pc_r;
        state_nxt_s = state_r;
        load_s      = 1'b0;
        clear_s     = 1'b0;
        stall_s     = 1'b0;
        if (trap_redir_i) begin
            pc_nxt_s    = trap_redir_pc_i;
            clear_s     = 1'b1;
            state_nxt_s = IFC_ST_RUN;
        end else if (ex_redir_i) begin
            pc_nxt_s    = ex_redir_pc_i;
            clear_s     = 1'b1;
            state_nxt_s = IFC_ST_RUN;
        end else begin
            case (state_r)
                IFC_ST_RUN: begin
                    if (accept_s) begin
                        pc_nxt_s = ifu_pc_next_i;
                        load_s   = 1'b1;
                        if (fetch_fault(ifu_pc_misalign_i, ifu_bus_err_i)) begin
                            state_nxt_s = IFC_ST_WAIT_TRAP;
                        end else begin
                            state_nxt_s = IFC_ST_RUN;
                        end
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                IFC_ST_WAIT_TRAP: begin
                    clear_s = id_ready_i;
                end
                default: begin
                    state_nxt_s = IFC_ST_RUN;
                end
            endcase
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            state_r <= IFC_ST_RUN;
        end else begin
            pc_r    <= pc_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    ifid_reg u_ifid (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .clear (clear_s),
        .d     (fetch_s),
        .valid (ID_valid_o),
        .q     (ifid_q_s)
    );

    assign IF_pc_o          = pc_r;
    assign ID_pc_o          = ifid_q_s.pc;
    assign ID_instr_o       = ifid_q_s.instr;
    assign ID_prdt_taken_o  = ifid_q_s.prdt_taken;
    assign ID_pc_misalign_o = ifid_q_s.pc_misalign;
    assign ID_bus_err_o     = ifid_q_s.bus_err;

`ifdef IFU_PERF_CNT_EN
    // Free-running wrapping event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_o <= 64'd0;
            perf_redir_cnt_o <= 64'd0;
            perf_stall_cnt_o <= 64'd0;
        end else begin
            perf_fetch_cnt_o <= perf_fetch_cnt_o + {63'd0, load_s};
            perf_redir_cnt_o <= perf_redir_cnt_o + {63'd0, (trap_redir_i | ex_redir_i)};
            perf_stall_cnt_o <= perf_stall_cnt_o + {63'd0, stall_s};
        end
    end
`endif

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed self-checking bench for if_pc_ctrl: sequencing, stall, redirects, fault parking, async reset.
module tb_if_pc_ctrl;
    import if_pc_ctrl_pkg::*;

    logic                   clk;
    logic                   rst;
    logic [PC_WIDTH-1:0]    if_pc;
    logic [PC_WIDTH-1:0]    ifu_pc_next;
    logic [INSTR_WIDTH-1:0] ifu_instr;
    logic                   ifu_prdt_taken;
    logic                   ifu_pc_misalign;
    logic                   ifu_bus_err;
    logic                   ex_redir;
    logic [PC_WIDTH-1:0]    ex_redir_pc;
    logic                   trap_redir;
    logic [PC_WIDTH-1:0]    trap_redir_pc;
    logic                   id_ready;
    logic                   id_valid;
    logic [PC_WIDTH-1:0]    id_pc;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic                   id_prdt_taken;
    logic                   id_pc_misalign;
    logic                   id_bus_err;
`ifdef IFU_PERF_CNT_EN
    logic [63:0]            perf_fetch_cnt;
    logic [63:0]            perf_redir_cnt;
    logic [63:0]            perf_stall_cnt;
`endif

    logic                   err_en;
    logic [PC_WIDTH-1:0]    err_pc;
    logic                   mis_en;
    logic [PC_WIDTH-1:0]    mis_pc;

    int n_checks;
    int n_fail;

    if_pc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .IF_pc_o           (if_pc),
        .ifu_pc_next_i     (ifu_pc_next),
        .ifu_instr_i       (ifu_instr),
        .ifu_prdt_taken_i  (ifu_prdt_taken),
        .ifu_pc_misalign_i (ifu_pc_misalign),
        .ifu_bus_err_i     (ifu_bus_err),
        .ex_redir_i        (ex_redir),
        .ex_redir_pc_i     (ex_redir_pc),
        .trap_redir_i      (trap_redir),
        .trap_redir_pc_i   (trap_redir_pc),
        .id_ready_i        (id_ready),
        .ID_valid_o        (id_valid),
        .ID_pc_o           (id_pc),
        .ID_instr_o        (id_instr),
        .ID_prdt_taken_o   (id_prdt_taken),
        .ID_pc_misalign_o  (id_pc_misalign),
        .ID_bus_err_o      (id_bus_err)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o  (perf_fetch_cnt),
        .perf_redir_cnt_o  (perf_redir_cnt),
        .perf_stall_cnt_o  (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequential fetch unit: next = pc+4, instr tagged by pc, faults injected at chosen addresses.
    assign ifu_pc_next     = if_pc + 64'd4;
    assign ifu_instr       = if_pc[31:0] ^ 32'h1357_0000;
    assign ifu_prdt_taken  = if_pc[2];
    assign ifu_bus_err     = err_en && (if_pc == err_pc);
    assign ifu_pc_misalign = mis_en && (if_pc == mis_pc);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        id_ready      = 1'b1;
        ex_redir      = 1'b0;
        ex_redir_pc   = 64'd0;
        trap_redir    = 1'b0;
        trap_redir_pc = 64'd0;
        err_en        = 1'b0;
        err_pc        = 64'd0;
        mis_en        = 1'b0;
        mis_pc        = 64'd0;
        tick();
        tick();
        check_eq("rst_if_pc",    if_pc,    64'h8000_0000);
        check_eq("rst_id_valid", {63'd0, id_valid}, 64'd0);
        check_eq("rst_id_pc",    id_pc,    64'd0);
        check_eq("rst_id_instr", {32'd0, id_instr}, 64'd0);

        rst = 1'b0;
        tick();
        check_eq("run0_if_pc",    if_pc,    64'h8000_0004);
        check_eq("run0_id_valid", {63'd0, id_valid}, 64'd1);
        check_eq("run0_id_pc",    id_pc,    64'h8000_0000);
        check_eq("run0_id_instr", {32'd0, id_instr}, 64'h9357_0000);
        tick();
        check_eq("run1_if_pc", if_pc, 64'h8000_0008);
        check_eq("run1_id_pc", id_pc, 64'h8000_0004);
        check_eq("run1_prdt",  {63'd0, id_prdt_taken}, 64'd1);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_if_pc",    if_pc, 64'h8000_0008);
            check_eq("stall_id_pc",    id_pc, 64'h8000_0004);
            check_eq("stall_id_valid", {63'd0, id_valid}, 64'd1);
            check_eq("stall_id_instr", {32'd0, id_instr}, 64'h9357_0004);
        end
        id_ready = 1'b1;
        tick();
        check_eq("unstall_if_pc", if_pc, 64'h8000_000C);
        check_eq("unstall_id_pc", id_pc, 64'h8000_0008);

        id_ready    = 1'b0;
        tick();
        check_eq("pre_redir_stall_if_pc", if_pc, 64'h8000_000C);
        ex_redir    = 1'b1;
        ex_redir_pc = 64'h8000_0100;
        tick();
        ex_redir = 1'b0;
        check_eq("exr_if_pc",    if_pc, 64'h8000_0100);
        check_eq("exr_id_valid", {63'd0, id_valid}, 64'd0);
        tick();
        check_eq("exr_fill_if_pc",    if_pc, 64'h8000_0104);
        check_eq("exr_fill_id_valid", {63'd0, id_valid}, 64'd1);
        check_eq("exr_fill_id_pc",    id_pc, 64'h8000_0100);
        check_eq("exr_fill_id_instr", {32'd0, id_instr}, 64'h9357_0100);
        id_ready = 1'b1;

        trap_redir    = 1'b1;
        trap_redir_pc = 64'h8000_0200;
        ex_redir      = 1'b1;
        ex_redir_pc   = 64'h8000_0100;
        tick();
        trap_redir = 1'b0;
        ex_redir   = 1'b0;
        check_eq("both_if_pc",    if_pc, 64'h8000_0200);
        check_eq("both_id_valid", {63'd0, id_valid}, 64'd0);
        tick();
        check_eq("both_fill_if_pc", if_pc, 64'h8000_0204);
        check_eq("both_fill_id_pc", id_pc, 64'h8000_0200);

        ex_redir    = 1'b1;
        ex_redir_pc = 64'h8000_0008;
        tick();
        ex_redir = 1'b0;
        err_en   = 1'b1;
        err_pc   = 64'h8000_0010;
        tick();
        tick();
        check_eq("pre_err_if_pc", if_pc, 64'h8000_0010);
        tick();
        check_eq("err_id_pc",      id_pc, 64'h8000_0010);
        check_eq("err_id_bus_err", {63'd0, id_bus_err}, 64'd1);
        check_eq("err_id_valid",   {63'd0, id_valid}, 64'd1);
        check_eq("err_if_pc",      if_pc, 64'h8000_0014);
        err_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("park_if_pc",    if_pc, 64'h8000_0014);
            check_eq("park_id_valid", {63'd0, id_valid}, 64'd0);
        end
        trap_redir    = 1'b1;
        trap_redir_pc = 64'h8000_0400;
        tick();
        trap_redir = 1'b0;
        check_eq("mtvec_if_pc", if_pc, 64'h8000_0400);
        tick();
        check_eq("mtvec_fill_if_pc",    if_pc, 64'h8000_0404);
        check_eq("mtvec_fill_id_pc",    id_pc, 64'h8000_0400);
        check_eq("mtvec_fill_id_valid", {63'd0, id_valid}, 64'd1);
        check_eq("mtvec_fill_bus_err",  {63'd0, id_bus_err}, 64'd0);

        mis_en = 1'b1;
        mis_pc = 64'h8000_0404;
        tick();
        check_eq("mis_id_misalign", {63'd0, id_pc_misalign}, 64'd1);
        check_eq("mis_if_pc",       if_pc, 64'h8000_0408);
        tick();
        check_eq("mis_park_if_pc", if_pc, 64'h8000_0408);
        ex_redir    = 1'b1;
        ex_redir_pc = 64'h8000_0500;
        tick();
        ex_redir = 1'b0;
        check_eq("ex_unpark_if_pc", if_pc, 64'h8000_0500);
        tick();
        check_eq("ex_unpark_fill_if_pc", if_pc, 64'h8000_0504);
        check_eq("ex_unpark_fill_id_pc", id_pc, 64'h8000_0500);

        mis_pc = 64'h8000_0504;
        tick();
        id_ready = 1'b0;
        tick();
        check_eq("park2_if_pc",    if_pc, 64'h8000_0508);
        check_eq("park2_id_valid", {63'd0, id_valid}, 64'd1);
        mis_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_if_pc",    if_pc, 64'h8000_0000);
        check_eq("async_rst_id_valid", {63'd0, id_valid}, 64'd0);
`ifdef IFU_PERF_CNT_EN
        check_eq("async_rst_perf_fetch", perf_fetch_cnt, 64'd0);
        check_eq("async_rst_perf_redir", perf_redir_cnt, 64'd0);
        check_eq("async_rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
        @(negedge clk);
        rst      = 1'b0;
        id_ready = 1'b1;
        tick();
        check_eq("post_rst_if_pc",    if_pc, 64'h8000_0004);
        check_eq("post_rst_id_valid", {63'd0, id_valid}, 64'd1);
        check_eq("post_rst_id_pc",    id_pc, 64'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
